// File: rtl/udp_cmd_rx.sv
// udp_cmd_rx: receive-side Ethernet/IPv4/UDP command filter.
// Consumes a GMII-style byte stream, filters frames by destination MAC, IPv4 and UDP
// port, validates the FCS and emits a 5-byte command (opcode + 32-bit argument) as a
// single-cycle strobe. Accepted and rejected frames are counted with saturating counters.
module udp_cmd_rx #(
   parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01,
   parameter logic [31:0] LOCAL_IP   = 32'hC0A8_010A,
   parameter logic [15:0] LOCAL_PORT = 16'd5000,
   parameter int          MAX_FRAME  = 1518
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        rx_dv,
   input  logic        rx_er,
   input  logic [7:0]  rx_data,
   output logic        cmd_valid,
   output logic [7:0]  cmd_op,
   output logic [31:0] cmd_arg,
   output logic [15:0] good_cnt,
   output logic [15:0] drop_cnt
);

   // Byte index counts bytes after the SFD; it must be able to reach MAX_FRAME+1.
   localparam int            IW          = $clog2(MAX_FRAME + 2);
   localparam logic [IW-1:0] IDX_MAX     = IW'(MAX_FRAME);
   localparam logic [IW-1:0] IDX_MIN     = IW'(64);
   localparam logic [IW-1:0] IDX_HDR_END = IW'(41);
   localparam logic [31:0]   CRC_SEED    = 32'hFFFF_FFFF;
   localparam logic [31:0]   CRC_RESIDUE = 32'hDEBB_20E3;
   localparam logic [31:0]   CRC_POLY    = 32'hEDB8_8320;

   typedef enum logic [2:0] {
      S_WAIT_IDLE,
      S_IDLE,
      S_PREAMBLE,
      S_HEADER,
      S_PAYLOAD,
      S_CHECK,
      S_DROP
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [IW-1:0] r_idx;
   logic [IW-1:0] w_idx_nxt;
   logic [IW-1:0] w_idx_inc;
   logic [31:0]   r_crc;
   logic [31:0]   w_crc_nxt;
   logic [31:0]   w_crc_upd;
   logic [7:0]    r_shadow_op;
   logic [31:0]   r_shadow_arg;
   logic          r_cmd_valid;
   logic [7:0]    r_cmd_op;
   logic [31:0]   r_cmd_arg;
   logic [15:0]   r_good_cnt;
   logic [15:0]   r_drop_cnt;
   logic [15:0]   w_good_nxt;
   logic [15:0]   w_drop_nxt;
   logic          w_accept;
   logic          w_drop;
   logic          w_pay_byte;
   logic          w_hdr_chk;
   logic [7:0]    w_hdr_exp;

   // Reflected CRC-32, one byte, LSB first.
   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc ^ {24'h0, d};
      for (int b = 0; b < 8; b++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

   assign w_crc_upd = crc_byte(r_crc, rx_data);
   // Index saturates one past MAX_FRAME so an oversize frame can never wrap back into range.
   assign w_idx_inc = (r_idx > IDX_MAX) ? r_idx : r_idx + IW'(1);

   // Header field lookup: which byte positions are checked and what they must contain.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
      w_hdr_chk = 1'b1;
      w_hdr_exp = 8'h00;
      case (int'(r_idx))
         0:       w_hdr_exp = LOCAL_MAC[47:40];
         1:       w_hdr_exp = LOCAL_MAC[39:32];
         2:       w_hdr_exp = LOCAL_MAC[31:24];
         3:       w_hdr_exp = LOCAL_MAC[23:16];
         4:       w_hdr_exp = LOCAL_MAC[15:8];
         5:       w_hdr_exp = LOCAL_MAC[7:0];
         12:      w_hdr_exp = 8'h08;
         13:      w_hdr_exp = 8'h00;
         14:      w_hdr_exp = 8'h45;
         23:      w_hdr_exp = 8'h11;
         30:      w_hdr_exp = LOCAL_IP[31:24];
         31:      w_hdr_exp = LOCAL_IP[23:16];
         32:      w_hdr_exp = LOCAL_IP[15:8];
         33:      w_hdr_exp = LOCAL_IP[7:0];
         36:      w_hdr_exp = LOCAL_PORT[15:8];
         37:      w_hdr_exp = LOCAL_PORT[7:0];
         default: w_hdr_chk = 1'b0;
      endcase
   end

   // Frame FSM: next state, byte index, CRC and accept/drop decisions.
   // The accept decision is taken on the edge that sees rx_dv fall (CRC and index are final
   // by then), so the registered strobe is visible during the single CHECK cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_crc_nxt   = r_crc;
      w_accept    = 1'b0;
      w_drop      = 1'b0;
      w_pay_byte  = 1'b0;
      unique case (r_state)
         S_WAIT_IDLE: begin
            if (!rx_dv) w_state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (rx_dv) begin
               w_state_nxt = (rx_er || rx_data != 8'h55) ? S_DROP : S_PREAMBLE;
            end
         end
         S_PREAMBLE: begin
            if (!rx_dv) begin
               w_state_nxt = S_IDLE;
               w_drop      = 1'b1;
            end else if (rx_er) begin
               w_state_nxt = S_DROP;
            end else if (rx_data == 8'hD5) begin
               w_state_nxt = S_HEADER;
               w_idx_nxt   = '0;
               w_crc_nxt   = CRC_SEED;
            end else if (rx_data != 8'h55) begin
               w_state_nxt = S_DROP;
            end
         end
         S_HEADER: begin
            if (!rx_dv) begin
               w_state_nxt = S_IDLE;
               w_drop      = 1'b1;
            end else if (rx_er || (w_hdr_chk && rx_data != w_hdr_exp)) begin
               w_state_nxt = S_DROP;
            end else begin
               w_crc_nxt = w_crc_upd;
               w_idx_nxt = w_idx_inc;
               if (r_idx == IDX_HDR_END) w_state_nxt = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (!rx_dv) begin
               w_state_nxt = S_CHECK;
               if (r_crc == CRC_RESIDUE && r_idx >= IDX_MIN && r_idx <= IDX_MAX) begin
                  w_accept = 1'b1;
               end else begin
                  w_drop = 1'b1;
               end
            end else if (rx_er) begin
               w_state_nxt = S_DROP;
            end else begin
               w_pay_byte = 1'b1;
               w_crc_nxt  = w_crc_upd;
               w_idx_nxt  = w_idx_inc;
               if (w_idx_inc > IDX_MAX) w_state_nxt = S_DROP;
            end
         end
         S_CHECK: begin
            w_state_nxt = S_IDLE;
         end
         S_DROP: begin
            if (!rx_dv) begin
               w_state_nxt = S_IDLE;
               w_drop      = 1'b1;
            end
         end
         default: w_state_nxt = S_WAIT_IDLE;
      endcase
   end

   assign w_good_nxt = (w_accept && r_good_cnt != 16'hFFFF) ? r_good_cnt + 16'd1 : r_good_cnt;
   assign w_drop_nxt = (w_drop && r_drop_cnt != 16'hFFFF) ? r_drop_cnt + 16'd1 : r_drop_cnt;

   // State, datapath and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rstn) begin
         r_state      <= S_WAIT_IDLE;
         r_idx        <= '0;
         r_crc        <= CRC_SEED;
         r_shadow_op  <= 8'h00;
         r_shadow_arg <= 32'h0;
         r_cmd_valid  <= 1'b0;
         r_cmd_op     <= 8'h00;
         r_cmd_arg    <= 32'h0;
         r_good_cnt   <= 16'h0;
         r_drop_cnt   <= 16'h0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_crc       <= w_crc_nxt;
         r_cmd_valid <= w_accept;
         r_good_cnt  <= w_good_nxt;
         r_drop_cnt  <= w_drop_nxt;
         if (w_accept) begin
            r_cmd_op  <= r_shadow_op;
            r_cmd_arg <= r_shadow_arg;
         end
         if (w_pay_byte) begin
            case (int'(r_idx))
               42:      r_shadow_op         <= rx_data;
               43:      r_shadow_arg[31:24] <= rx_data;
               44:      r_shadow_arg[23:16] <= rx_data;
               45:      r_shadow_arg[15:8]  <= rx_data;
               46:      r_shadow_arg[7:0]   <= rx_data;
               default: ;
            endcase
         end
      end
   end

   assign cmd_valid = r_cmd_valid;
   assign cmd_op    = r_cmd_op;
   assign cmd_arg   = r_cmd_arg;
   assign good_cnt  = r_good_cnt;
   assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_udp_cmd_rx.sv
// tb_udp_cmd_rx: scoreboard bench for udp_cmd_rx. Frames are built byte by byte, the
// reference model decides acceptance from the frame contents, and a negedge monitor pops
// expected commands whenever cmd_valid is seen.
module tb_udp_cmd_rx;

   localparam logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01;
   localparam logic [31:0] LOCAL_IP   = 32'hC0A8_010A;
   localparam logic [15:0] LOCAL_PORT = 16'd5000;
   localparam int          MAX_FRAME  = 1518;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        rx_dv = 1'b0;
   logic        rx_er = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        cmd_valid;
   logic [7:0]  cmd_op;
   logic [31:0] cmd_arg;
   logic [15:0] good_cnt;
   logic [15:0] drop_cnt;

   udp_cmd_rx #(
      .LOCAL_MAC (LOCAL_MAC),
      .LOCAL_IP  (LOCAL_IP),
      .LOCAL_PORT(LOCAL_PORT),
      .MAX_FRAME (MAX_FRAME)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .rx_dv    (rx_dv),
      .rx_er    (rx_er),
      .rx_data  (rx_data),
      .cmd_valid(cmd_valid),
      .cmd_op   (cmd_op),
      .cmd_arg  (cmd_arg),
      .good_cnt (good_cnt),
      .drop_cnt (drop_cnt)
   );

   always #4 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] arg;
      int          cyc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic [7:0]  frm[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          exp_good = 0;
   int          exp_drop = 0;
   logic [7:0]  hold_op = 8'h00;
   logic [31:0] hold_arg = 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] crc32(input logic [7:0] f[$], input int n);
      logic [31:0] c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'h0, f[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   function automatic bit model_accept(input logic [7:0] f[$], input bit er);
      int n = f.size();
      logic [31:0] fcs;
      if (er || n < 64 || n > MAX_FRAME) return 1'b0;
      if ({f[0], f[1], f[2], f[3], f[4], f[5]} != LOCAL_MAC) return 1'b0;
      if ({f[12], f[13]} != 16'h0800) return 1'b0;
      if (f[14] != 8'h45 || f[23] != 8'h11) return 1'b0;
      if ({f[30], f[31], f[32], f[33]} != LOCAL_IP) return 1'b0;
      if ({f[36], f[37]} != LOCAL_PORT) return 1'b0;
      fcs = ~crc32(f, n - 4);
      return {f[n-1], f[n-2], f[n-3], f[n-4]} == fcs;
   endfunction

   function automatic int sat_inc(input int v);
      return (v < 65535) ? v + 1 : 65535;
   endfunction

   // Builds a complete frame (dst MAC through FCS) into frm.
   task automatic build(input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] port,
                        input logic [15:0] etype, input logic [7:0] op, input logic [31:0] arg,
                        input int pay_len);
      logic [7:0]  pay[$];
      logic [47:0] src_mac = 48'h02_00_00_00_00_99;
      logic [15:0] ip_len;
      logic [15:0] udp_len;
      logic [31:0] fcs;
      ip_len  = 16'(28 + pay_len);
      udp_len = 16'(8 + pay_len);
      frm = {};
      for (int i = 5; i >= 0; i--) frm.push_back(mac[8*i +: 8]);
      for (int i = 5; i >= 0; i--) frm.push_back(src_mac[8*i +: 8]);
      frm.push_back(etype[15:8]);  frm.push_back(etype[7:0]);
      frm.push_back(8'h45);        frm.push_back(8'h00);
      frm.push_back(ip_len[15:8]); frm.push_back(ip_len[7:0]);
      frm.push_back(8'h00);        frm.push_back(8'h00);
      frm.push_back(8'h40);        frm.push_back(8'h00);
      frm.push_back(8'h40);        frm.push_back(8'h11);
      frm.push_back(8'h00);        frm.push_back(8'h00);
      frm.push_back(8'hC0); frm.push_back(8'hA8); frm.push_back(8'h01); frm.push_back(8'h02);
      for (int i = 3; i >= 0; i--) frm.push_back(ip[8*i +: 8]);
      frm.push_back(8'hC3);         frm.push_back(8'h50);
      frm.push_back(port[15:8]);    frm.push_back(port[7:0]);
      frm.push_back(udp_len[15:8]); frm.push_back(udp_len[7:0]);
      frm.push_back(8'h00);         frm.push_back(8'h00);
      pay = {op, arg[31:24], arg[23:16], arg[15:8], arg[7:0]};
      while (pay.size() < pay_len) pay.push_back(8'($urandom));
      for (int i = 0; i < pay_len; i++) frm.push_back(pay[i]);
      fcs = ~crc32(frm, frm.size());
      for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic dv, input logic er, input logic [7:0] d);
      @(negedge clk);
      rx_dv   = dv;
      rx_er   = er;
      rx_data = d;
   endtask

   // Sends frm with the given preamble length. er_at/rst_at < 0 disable error/reset injection.
   task automatic send(input int pre, input int er_at, input int rst_at, input int gap, input bit chk);
      bit   acc;
      exp_t e;
      acc = (rst_at < 0) && model_accept(frm, er_at >= 0);
      for (int i = 0; i < pre; i++) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int i = 0; i < frm.size(); i++) begin
         drive(1'b1, i == er_at, frm[i]);
         if (i == rst_at) rstn = 1'b0;
         if (rst_at >= 0 && i == rst_at + 1) begin
            hold_op  = 8'h00;
            hold_arg = 32'h0;
            exp_good = 0;
            exp_drop = 0;
         end
         if (rst_at >= 0 && i == rst_at + 2) rstn = 1'b1;
      end
      drive(1'b0, 1'b0, 8'h00);
      if (rst_at < 0) begin
         if (acc) begin
            e.op  = frm[42];
            e.arg = {frm[43], frm[44], frm[45], frm[46]};
            e.cyc = cyc + 1;
            sb_q.push_back(e);
            exp_good = sat_inc(exp_good);
         end else begin
            exp_drop = sat_inc(exp_drop);
         end
      end
      for (int i = 1; i < gap; i++) drive(1'b0, 1'b0, 8'h00);
      if (chk) begin
         repeat (3) drive(1'b0, 1'b0, 8'h00);
         check("good_cnt", 64'(good_cnt), 64'(exp_good));
         check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
         check("cmd_pending", 64'(sb_q.size()), 64'(0));
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rstn) begin
         if (cmd_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_cmd: got op %0h arg %0h, expected no command (cycle %0d)",
                        cmd_op, cmd_arg, cyc);
            end else begin
               mon_e = sb_q.pop_front();
               check("cmd_op", 64'(cmd_op), 64'(mon_e.op));
               check("cmd_arg", 64'(cmd_arg), 64'(mon_e.arg));
               check("cmd_latency", 64'(cyc), 64'(mon_e.cyc));
               hold_op  = mon_e.op;
               hold_arg = mon_e.arg;
            end
         end else begin
            check("cmd_op_hold", 64'(cmd_op), 64'(hold_op));
            check("cmd_arg_hold", 64'(cmd_arg), 64'(hold_arg));
         end
      end
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int kind, pay, pre, gap, er_at, cut, k;
      logic [47:0] mac;
      logic [31:0] ip;
      logic [15:0] port;
      bit chk;

      repeat (3) @(negedge clk);
      check("rst_cmd_valid", 64'(cmd_valid), 64'(0));
      check("rst_cmd_op", 64'(cmd_op), 64'(0));
      check("rst_cmd_arg", 64'(cmd_arg), 64'(0));
      check("rst_good_cnt", 64'(good_cnt), 64'(0));
      check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
      rstn = 1'b1;
      repeat (3) drive(1'b0, 1'b0, 8'h00);

      // Good frame, then the same frame with a flipped payload bit.
      build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 16'h0800, 8'h01, 32'h0000_1000, 18);
      send(7, -1, -1, 1, 1'b1);
      frm[44] = frm[44] ^ 8'h04;
      send(7, -1, -1, 1, 1'b1);

      // Wrong MAC, wrong port, ARP ethertype.
      build(48'h02_00_00_00_00_02, LOCAL_IP, LOCAL_PORT, 16'h0800, 8'h02, 32'h1, 18);
      send(7, -1, -1, 1, 1'b1);
      build(LOCAL_MAC, LOCAL_IP, 16'd5001, 16'h0800, 8'h03, 32'h2, 18);
      send(7, -1, -1, 1, 1'b1);
      build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 16'h0806, 8'h04, 32'h3, 18);
      send(7, -1, -1, 1, 1'b1);

      // rx_er at byte 20, then a good frame after a single idle cycle.
      build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 16'h0800, 8'h05, 32'hDEAD_BEEF, 30);
      send(7, 20, -1, 1, 1'b0);
      build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 16'h0800, 8'h06, 32'hCAFE_0001, 30);
      send(7, -1, -1, 1, 1'b1);

      // Reset asserted for two cycles at byte 30, then a good frame.
      build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 16'h0800, 8'h07, 32'h1234_5678, 20);
      send(7, -1, 30, 1, 1'b1);
      build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 16'h0800, 8'h08, 32'h8765_4321, 20);
      send(3, -1, -1, 1, 1'b1);

      // Length boundaries: 1600 and 60 dropped; 1518 and 64 accepted; 1519 and 63 dropped.
      build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 16'h0800, 8'h09, 32'h9, 1554);
      send(7, -1, -1, 1, 1'b1);
      build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 16'h0800, 8'h0A, 32'hA, 14);
      send(7, -1, -1, 1, 1'b1);
      build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 16'h0800, 8'h0B, 32'hB, 1472);
      send(7, -1, -1, 1, 1'b1);
      build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 16'h0800, 8'h0C, 32'hC, 1473);
      send(7, -1, -1, 1, 1'b1);
      build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 16'h0800, 8'h0D, 32'hD, 18);
      send(7, -1, -1, 1, 1'b1);
      build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 16'h0800, 8'h0E, 32'hE, 17);
      send(7, -1, -1, 1, 1'b1);

      // Randomized mix of good and faulty frames.
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 9);
         pay  = (kind == 8) ? $urandom_range(5, 17) : $urandom_range(18, 80);
         mac  = LOCAL_MAC;
         ip   = LOCAL_IP;
         port = LOCAL_PORT;
         if (kind == 3) mac  = mac ^ (48'h1 << $urandom_range(0, 47));
         if (kind == 4) port = port ^ (16'h1 << $urandom_range(0, 15));
         if (kind == 5) ip   = ip ^ (32'h1 << $urandom_range(0, 31));
         build(mac, ip, port, 16'h0800, 8'($urandom), $urandom, pay);
         if (kind == 6) begin
            k = 42 + $urandom_range(0, pay - 1);
            frm[k] = frm[k] ^ 8'(1 << $urandom_range(0, 7));
         end
         if (kind == 9) begin
            cut = $urandom_range(1, 41);
            while (frm.size() > cut) void'(frm.pop_back());
         end
         er_at = (kind == 7) ? $urandom_range(0, frm.size() - 1) : -1;
         pre   = $urandom_range(2, 7);
         gap   = $urandom_range(1, 4);
         chk   = ($urandom_range(0, 1) == 1);
         send(pre, er_at, -1, gap, chk);
      end
      repeat (3) drive(1'b0, 1'b0, 8'h00);
      check("rand_good_cnt", 64'(good_cnt), 64'(exp_good));
      check("rand_drop_cnt", 64'(drop_cnt), 64'(exp_drop));

      // Drop counter saturation.
      force dut.r_drop_cnt = 16'hFFFF;
      repeat (2) @(negedge clk);
      release dut.r_drop_cnt;
      exp_drop = 65535;
      build(LOCAL_MAC, LOCAL_IP, LOCAL_PORT, 16'h0800, 8'h0F, 32'hF, 18);
      frm[50] = frm[50] ^ 8'h80;
      send(7, -1, -1, 1, 1'b1);

      repeat (5) drive(1'b0, 1'b0, 8'h00);
      check("final_pending", 64'(sb_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
